// File: rtl/gr_wb_sched.sv
// gr_wb_sched: round-robin write-back arbiter and register scoreboard; GR_BYPASS_EN adds same-cycle forwarding
module gr_wb_sched #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic [2:0]        req_v,
    input  logic [3*AW-1:0]   req_n,
    input  logic [3*XLEN-1:0] req_d,
    output logic [2:0]        req_rdy,
    output logic              gr_rd,
    output logic [AW-1:0]     gr_rd_n,
    output logic [XLEN-1:0]   gr_wd,
    input  logic              alloc,
    input  logic [AW-1:0]     alloc_n,
    output logic              alloc_stall,
    input  logic              rs1,
    input  logic [AW-1:0]     rs1_n,
    input  logic              rs2,
    input  logic [AW-1:0]     rs2_n,
    output logic              rs1_stall,
    output logic              rs2_stall,
    output logic              s1_fwd,
    output logic              s2_fwd,
    output logic [XLEN-1:0]   fwd_d,
    output logic              sb_err
);
    localparam int NREG = 2**AW;
    logic [NREG-1:0] busy;
    logic [1:0]      rr_ptr, o1, o2, gi;
    logic            any, grant, byp1, byp2;
    logic [AW-1:0]   rn [4];
    logic [XLEN-1:0] rd [4];
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rn[k] = req_n[AW*k +: AW];
            rd[k] = req_d[XLEN*k +: XLEN];
        end
        rn[3] = '0;
        rd[3] = '0;
        o1 = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
        o2 = (rr_ptr == 2'd0) ? 2'd2 : rr_ptr - 2'd1;
        gi = req_v[rr_ptr] ? rr_ptr : req_v[o1] ? o1 : o2;
        any = |req_v;
        grant = any & ~p_reset;
        req_rdy = grant ? 3'b001 << gi : 3'b000;
        gr_rd_n = grant ? rn[gi] : '0;
        gr_wd = grant ? rd[gi] : '0;
        gr_rd = grant & (rn[gi] != '0);
        // a write landing this cycle frees the register in time for the new reservation
        alloc_stall = alloc & busy[alloc_n] & ~(gr_rd & (gr_rd_n == alloc_n));
`ifdef GR_BYPASS_EN
        byp1 = gr_rd & (gr_rd_n == rs1_n);
        byp2 = gr_rd & (gr_rd_n == rs2_n);
        fwd_d = gr_wd;
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
        fwd_d = '0;
`endif
        s1_fwd = byp1;
        s2_fwd = byp2;
        rs1_stall = rs1 & (rs1_n != '0) & busy[rs1_n] & ~byp1;
        rs2_stall = rs2 & (rs2_n != '0) & busy[rs2_n] & ~byp2;
    end
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            busy <= '0;
            rr_ptr <= 2'd0;
            sb_err <= 1'b0;
        end else begin
            if (gr_rd) busy[gr_rd_n] <= 1'b0;
            if (alloc & ~alloc_stall & (alloc_n != '0)) busy[alloc_n] <= 1'b1;
            if (any) rr_ptr <= (gi == 2'd2) ? 2'd0 : gi + 2'd1;
            sb_err <= sb_err | alloc_stall;
        end
    end
endmodule
